tv_key_state_gate: RTL



---
 rtl/tv_lock_pkg.sv | 49 ++++
 rtl/tv_epoch_counter.sv | 48 ++++
 rtl/tv_key_state_gate.sv | 89 ++++++++
 3 files changed

// File: rtl/tv_lock_pkg.sv
// Shared helpers for the time-varying key gate.
// Contents:
//   clog2_min1  - ceil(log2(n)), never less than 1 (for index widths)
//   epoch_w     - width of the epoch index for a given epoch count
//   key_slice   - extract key slice e (width w) from the packed key table
//   decoy_slice - extract decoy slice e (width w) from the packed decoy table
// Packed tables are passed zero-extended to PACK_MAX bits. Slices are
// returned in SLICE_MAX bits and truncated by the caller.
package tv_lock_pkg;

  localparam int PACK_MAX  = 1024;
  localparam int SLICE_MAX = 64;

  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int epoch_w(input int num_epochs);
    return clog2_min1(num_epochs);
  endfunction

  function automatic logic [SLICE_MAX-1:0] width_mask(input int w);
    logic [SLICE_MAX-1:0] m;
    if (w >= SLICE_MAX) m = '1;
    else m = (64'd1 << w) - 64'd1;
    return m;
  endfunction

  function automatic logic [SLICE_MAX-1:0] slice_of(input logic [PACK_MAX-1:0] tbl,
                                                    input int e, input int w);
    logic [PACK_MAX-1:0] sh;
    sh = tbl >> (e * w);
    return sh[SLICE_MAX-1:0] & width_mask(w);
  endfunction

  function automatic logic [SLICE_MAX-1:0] key_slice(input logic [PACK_MAX-1:0] keys,
                                                     input int e, input int w);
    return slice_of(keys, e, w);
  endfunction

  function automatic logic [SLICE_MAX-1:0] decoy_slice(input logic [PACK_MAX-1:0] decoys,
                                                       input int e, input int w);
    return slice_of(decoys, e, w);
  endfunction

endpackage

// File: rtl/tv_epoch_counter.sv
// Epoch sequencer: counts advancing cycles within an epoch and steps the
// epoch index (wrapping to 0) after EPOCH_LEN advancing cycles.
// Ports:
//   clk   - clock
//   rst   - synchronous active-high reset (cnt=0, epoch=0)
//   adv   - advance qualifier; counter holds when low
//   epoch - current epoch index
module tv_epoch_counter
  import tv_lock_pkg::*;
#(
  parameter int NUM_EPOCHS = 2,
  parameter int EPOCH_LEN  = 5
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             adv,
  output logic [epoch_w(NUM_EPOCHS)-1:0]   epoch
);

  localparam int CNT_W = clog2_min1(EPOCH_LEN);
  localparam int EW    = epoch_w(NUM_EPOCHS);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(EPOCH_LEN - 1);
  localparam logic [EW-1:0]    EPOCH_LAST = EW'(NUM_EPOCHS - 1);

  if (NUM_EPOCHS < 1) begin : g_bad_epochs
    $error("tv_epoch_counter: NUM_EPOCHS must be >= 1");
  end
  if (EPOCH_LEN < 1) begin : g_bad_len
    $error("tv_epoch_counter: EPOCH_LEN must be >= 1");
  end

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      epoch <= '0;
    end else if (adv) begin
      if (cnt == CNT_LAST) begin
        cnt   <= '0;
        epoch <= (epoch == EPOCH_LAST) ? '0 : epoch + EW'(1);
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/tv_key_state_gate.sv
// Time-varying key gate owning the present-state register of a locked FSM.
// On each advancing edge the key is compared against the current epoch's
// key; a match loads nx_state, a mismatch loads the epoch's decoy state.
// Ports:
//   clk      - clock
//   rst      - synchronous active-high reset
//   adv      - advance qualifier; all registers hold when low
//   key_in   - key presented this cycle
//   nx_state - next state from the host FSM
//   pr_state - registered present state
//   epoch    - current epoch index
//   key_ok   - registered result of the last evaluated compare
//   tamper   - sticky tamper flag (constant 0 unless STICKY)
//   miss_cnt - saturating count of mismatching advancing cycles
module tv_key_state_gate
  import tv_lock_pkg::*;
#(
  parameter int STATE_W    = 6,
  parameter int KEY_W      = 5,
  parameter int NUM_EPOCHS = 2,
  parameter int EPOCH_LEN  = 5,
  parameter logic [STATE_W-1:0] RESET_STATE = 1,
  parameter logic [NUM_EPOCHS*KEY_W-1:0]   KEYS   = {5'd11, 5'd17},
  parameter logic [NUM_EPOCHS*STATE_W-1:0] DECOYS = {6'd2, 6'd34},
  parameter bit   STICKY     = 1'b0,
  parameter int   MISS_W     = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           adv,
  input  logic [KEY_W-1:0]               key_in,
  input  logic [STATE_W-1:0]             nx_state,
  output logic [STATE_W-1:0]             pr_state,
  output logic [epoch_w(NUM_EPOCHS)-1:0] epoch,
  output logic                           key_ok,
  output logic                           tamper,
  output logic [MISS_W-1:0]              miss_cnt
);

  if (NUM_EPOCHS < 1) begin : g_bad_epochs
    $error("tv_key_state_gate: NUM_EPOCHS must be >= 1");
  end
  if (EPOCH_LEN < 1) begin : g_bad_len
    $error("tv_key_state_gate: EPOCH_LEN must be >= 1");
  end
  if (KEY_W > SLICE_MAX || STATE_W > SLICE_MAX ||
      NUM_EPOCHS * KEY_W > PACK_MAX || NUM_EPOCHS * STATE_W > PACK_MAX) begin : g_bad_tbl
    $error("tv_key_state_gate: key/decoy tables exceed helper limits");
  end

  tv_epoch_counter #(
    .NUM_EPOCHS (NUM_EPOCHS),
    .EPOCH_LEN  (EPOCH_LEN)
  ) u_epoch (
    .clk   (clk),
    .rst   (rst),
    .adv   (adv),
    .epoch (epoch)
  );

  logic [KEY_W-1:0]   key_exp;
  logic [STATE_W-1:0] decoy;
  logic               match;
  logic               pass;

  // Compare uses the pre-edge epoch so key, decoy and sequencing agree.
  assign key_exp = KEY_W'(key_slice(PACK_MAX'(KEYS), int'(epoch), KEY_W));
  assign decoy   = STATE_W'(decoy_slice(PACK_MAX'(DECOYS), int'(epoch), STATE_W));
  assign match   = (key_in == key_exp);
  // Tamper already latched blocks the state even with a correct key.
  assign pass    = match && !(STICKY && tamper);

  always_ff @(posedge clk) begin
    if (rst) begin
      pr_state <= RESET_STATE;
      key_ok   <= 1'b0;
      tamper   <= 1'b0;
      miss_cnt <= '0;
    end else if (adv) begin
      pr_state <= pass ? nx_state : decoy;
      key_ok   <= match;
      if (!match) begin
        if (miss_cnt != {MISS_W{1'b1}}) miss_cnt <= miss_cnt + MISS_W'(1);
        if (STICKY) tamper <= 1'b1;
      end
    end
  end

endmodule
